// File: rtl/mla_pkg.sv
// rtl/mla_pkg.sv - shared state encoding and default geometry for the multi-line animator
package mla_pkg;

    typedef enum logic [2:0] {
        S_START   = 3'd0,
        S_DRAW    = 3'd1,
        S_IDLE    = 3'd2,
        S_ERASE   = 3'd3,
        S_ADVANCE = 3'd4
    } state_e;

    localparam int MLA_CW      = 11;
    localparam int MLA_NLINES  = 2;
    localparam int MLA_STEPS   = 128;
    localparam int MLA_LEN_X   = 30;
    localparam int MLA_LEN_Y   = 20;
    localparam int MLA_SPACING = 40;

endpackage

// File: rtl/line_drawer.sv
// rtl/line_drawer.sv - Bresenham walker: rst loads endpoints, one pixel per cycle, then holds finished
module line_drawer #(
    parameter int CW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] x0,
    input  logic [CW-1:0] y0,
    input  logic [CW-1:0] x1,
    input  logic [CW-1:0] y1,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          finished
);

    localparam int EW = CW + 3;

    logic [CW-1:0]        x_q, x_d, y_q, y_d, xe_q, xe_d, ye_q, ye_d;
    logic signed [EW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                 sx_q, sx_d, sy_q, sy_d, fin_q, fin_d;

    logic [CW-1:0]        dxr, dyr;
    logic signed [EW-1:0] sdx, sdy, adx, ady, e2, err_n;

    // Endpoint differences are modulo 2^CW, so read them as signed CW-bit values.
    assign dxr = x1 - x0;
    assign dyr = y1 - y0;
    assign sdx = {{3{dxr[CW-1]}}, dxr};
    assign sdy = {{3{dyr[CW-1]}}, dyr};
    assign adx = sdx[EW-1] ? -sdx : sdx;
    assign ady = sdy[EW-1] ? -sdy : sdy;

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        xe_d  = xe_q;
        ye_d  = ye_q;
        dx_d  = dx_q;
        dy_d  = dy_q;
        err_d = err_q;
        sx_d  = sx_q;
        sy_d  = sy_q;
        fin_d = fin_q;
        e2    = err_q <<< 1;
        err_n = err_q;
        if (rst) begin
            x_d   = x0;
            y_d   = y0;
            xe_d  = x1;
            ye_d  = y1;
            dx_d  = adx;
            dy_d  = -ady;
            err_d = adx - ady;
            sx_d  = sdx[EW-1];
            sy_d  = sdy[EW-1];
            fin_d = 1'b0;
        end else if (!fin_q) begin
            if (x_q == xe_q && y_q == ye_q) begin
                fin_d = 1'b1;
            end else begin
                if (e2 >= dy_q) begin
                    err_n = err_n + dy_q;
                    x_d   = sx_q ? x_q - CW'(1) : x_q + CW'(1);
                end
                if (e2 <= dx_q) begin
                    err_n = err_n + dx_q;
                    y_d   = sy_q ? y_q - CW'(1) : y_q + CW'(1);
                end
                err_d = err_n;
            end
        end
    end

    always_ff @(posedge clk) begin
        x_q   <= x_d;
        y_q   <= y_d;
        xe_q  <= xe_d;
        ye_q  <= ye_d;
        dx_q  <= dx_d;
        dy_q  <= dy_d;
        err_q <= err_d;
        sx_q  <= sx_d;
        sy_q  <= sy_d;
        fin_q <= fin_d;
    end

    assign x        = x_q;
    assign y        = y_q;
    assign finished = fin_q;

endmodule

// File: rtl/multi_line_animator.sv
// rtl/multi_line_animator.sv - draws/erases NLINES parallel lines per step; MULTI_LINE_ANIMATOR_BOUNCE_EN adds bounce mode
module multi_line_animator
    import mla_pkg::*;
#(
    parameter int CW      = MLA_CW,
    parameter int NLINES  = MLA_NLINES,
    parameter int STEPS   = MLA_STEPS,
    parameter int LEN_X   = MLA_LEN_X,
    parameter int LEN_Y   = MLA_LEN_Y,
    parameter int SPACING = MLA_SPACING
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          update_event,
    input  logic          pause,
    input  logic          mode,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          pixel_color,
    output logic          pixel_valid,
    output logic          frame_done
);

    localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int LW = (NLINES > 1) ? $clog2(NLINES) : 1;

    state_e        state_q, state_d;
    logic [SW-1:0] step_q, step_d;
    logic [LW-1:0] line_q, line_d;
    logic          pending_q, pending_d;
    logic          drv_rst, fin, last, go;
    logic [CW-1:0] ex0, ey0, ex1, ey1, line_off;

`ifdef MULTI_LINE_ANIMATOR_BOUNCE_EN
    logic dir_q, dir_d;
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    assign last = (line_q == LW'(NLINES - 1));
    assign go   = (update_event || pending_q) && !pause;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_START;
            step_q    <= '0;
            line_q    <= '0;
            pending_q <= 1'b0;
`ifdef MULTI_LINE_ANIMATOR_BOUNCE_EN
            dir_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            line_q    <= line_d;
            pending_q <= pending_d;
`ifdef MULTI_LINE_ANIMATOR_BOUNCE_EN
            dir_q     <= dir_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        line_d    = line_q;
        pending_d = pending_q;
`ifdef MULTI_LINE_ANIMATOR_BOUNCE_EN
        dir_d     = dir_q;
`endif
        if (update_event && state_q != S_IDLE) pending_d = 1'b1;
        case (state_q)
            S_START: begin
                line_d  = '0;
                state_d = S_DRAW;
            end
            S_DRAW, S_ERASE: begin
                if (fin) begin
                    if (last) state_d = (state_q == S_DRAW) ? S_IDLE : S_ADVANCE;
                    else      line_d  = line_q + LW'(1);
                end
            end
            S_IDLE: begin
                if (go) begin
                    state_d   = S_ERASE;
                    line_d    = '0;
                    pending_d = 1'b0;
                end
            end
            S_ADVANCE: begin
                line_d  = '0;
                state_d = S_DRAW;
                step_d  = (step_q == SW'(STEPS - 1)) ? '0 : step_q + SW'(1);
`ifdef MULTI_LINE_ANIMATOR_BOUNCE_EN
                // dir flips when leaving an endpoint, so each end is shown once per turn.
                if (mode) begin
                    if (!dir_q) begin
                        if (step_q == SW'(STEPS - 1)) begin
                            dir_d  = 1'b1;
                            step_d = step_q - SW'(1);
                        end else begin
                            step_d = step_q + SW'(1);
                        end
                    end else begin
                        if (step_q == '0) begin
                            dir_d  = 1'b0;
                            step_d = step_q + SW'(1);
                        end else begin
                            step_d = step_q - SW'(1);
                        end
                    end
                end
`endif
            end
            default: state_d = S_START;
        endcase
    end

    always_comb begin
        drv_rst     = 1'b0;
        pixel_color = (state_q == S_DRAW);
        case (state_q)
            S_START, S_ADVANCE: drv_rst = 1'b1;
            S_DRAW, S_ERASE:    drv_rst = fin && !last;
            S_IDLE:             drv_rst = go;
            default:            drv_rst = 1'b0;
        endcase
        pixel_valid = (state_q == S_DRAW || state_q == S_ERASE) && !drv_rst && !fin;
        frame_done  = (state_q == S_DRAW) && fin && last;
    end

    // The drawer loads the line/step that will be current after this edge.
    assign line_off = CW'(SPACING * int'(line_d));
    assign ex0      = CW'(step_d);
    assign ey0      = ex0 + line_off;
    assign ex1      = ex0 + CW'(LEN_X);
    assign ey1      = ey0 + CW'(LEN_Y);

    line_drawer #(.CW(CW)) u_drawer (
        .clk      (clk),
        .rst      (reset || drv_rst),
        .x0       (ex0),
        .y0       (ey0),
        .x1       (ex1),
        .y1       (ey1),
        .x        (x),
        .y        (y),
        .finished (fin)
    );

endmodule

// File: tb/tb_multi_line_animator.sv
// tb/tb_multi_line_animator.sv - scoreboard bench for multi_line_animator (wrap, pending, pause, reset, mode)
module tb_multi_line_animator;

    localparam int CW = 11;
    localparam int NL = 2;
    localparam int ST = 4;
    localparam int LX = 30;
    localparam int LY = 20;
    localparam int SP = 40;
    localparam int MASK = (1 << CW) - 1;

    logic          clk, reset, update_event, pause, mode;
    logic [CW-1:0] x, y;
    logic          pixel_color, pixel_valid, frame_done;

    logic [31:0] exp_q[$];
    int vectors, miscompares;
    int fd_count, pix_count, exp_frames, mstep;

    multi_line_animator #(
        .CW(CW), .NLINES(NL), .STEPS(ST), .LEN_X(LX), .LEN_Y(LY), .SPACING(SP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .update_event (update_event),
        .pause        (pause),
        .mode         (mode),
        .x            (x),
        .y            (y),
        .pixel_color  (pixel_color),
        .pixel_valid  (pixel_valid),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_px(input int px, input int py, input int c);
        return 32'(((px & MASK) << (CW + 1)) | ((py & MASK) << 1) | (c & 1));
    endfunction

    // Reference x-major Bresenham: 2*dy-dx decision, y advances on a non-negative decision.
    task automatic push_pass(input int s, input int c);
        for (int k = 0; k < NL; k++) begin
            int d, yo;
            d  = 2 * LY - LX;
            yo = 0;
            for (int i = 0; i <= LX; i++) begin
                exp_q.push_back(pack_px(s + i, s + k * SP + yo, c));
                if (d >= 0) begin
                    yo++;
                    d -= 2 * LX;
                end
                d += 2 * LY;
            end
        end
    endtask

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_count++;
        if (pixel_valid === 1'b1) begin
            pix_count++;
            if (exp_q.size() == 0) check("px_unexpected", 32'(pixel_valid), 32'd0);
            else check("px", pack_px(int'(x), int'(y), int'(pixel_color)), exp_q.pop_front());
        end
    end

    task automatic pulse_update();
        @(posedge clk); #1 update_event = 1'b1;
        @(posedge clk); #1 update_event = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        int start, n;
        start = fd_count;
        n = 0;
        while (fd_count == start && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1 check(tag, 32'(fd_count != start), 32'd1);
    endtask

    task automatic wait_pixel(input string tag, input logic col);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(pixel_valid === 1'b1 && pixel_color === col) && n < 2000);
        check(tag, 32'(pixel_valid === 1'b1 && pixel_color === col), 32'd1);
    endtask

    task automatic do_update(input int nxt);
        push_pass(mstep, 0);
        mstep = nxt;
        push_pass(mstep, 1);
        exp_frames++;
        pulse_update();
        wait_frame("frame_upd");
    endtask

    initial begin
        int pc;
        int bseq[7];
        bseq = '{1, 2, 3, 2, 1, 0, 1};
        vectors = 0; miscompares = 0; fd_count = 0; pix_count = 0;
        reset = 1'b1; update_event = 1'b0; pause = 1'b0; mode = 1'b0;
        mstep = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(pixel_valid), 32'd0);
        check("rst_color", 32'(pixel_color), 32'd0);
        check("rst_fdone", 32'(frame_done), 32'd0);
        push_pass(0, 1);
        exp_frames = 1;
        reset = 1'b0;
        wait_frame("frame0");
        repeat (20) @(posedge clk);
        check("frame0_drained", 32'(exp_q.size()), 32'd0);
        check("frame0_pulses", 32'(fd_count), 32'd1);

        for (int i = 0; i < 4; i++) do_update((mstep + 1) % ST);
        check("wrap_step", 32'(mstep), 32'd0);

        pulse_update();
        push_pass(mstep, 0);
        mstep = (mstep + 1) % ST;
        push_pass(mstep, 1);
        wait_pixel("t36_drawing", 1'b1);
        @(posedge clk); #1 pause = 1'b1;
        pulse_update();
        repeat (3) @(posedge clk);
        pulse_update();
        push_pass(mstep, 0);
        mstep = (mstep + 1) % ST;
        push_pass(mstep, 1);
        exp_frames += 2;
        wait_frame("t36_first");
        pc = pix_count;
        repeat (60) @(posedge clk);
        #1 check("pause_hold_px", 32'(pix_count - pc), 32'd0);
        pause = 1'b0;
        wait_frame("t36_second");
        repeat (100) @(posedge clk);
        check("t36_drained", 32'(exp_q.size()), 32'd0);

        push_pass(mstep, 0);
        pulse_update();
        wait_pixel("t37_erasing", 1'b0);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        check("midrst_valid", 32'(pixel_valid), 32'd0);
        check("midrst_color", 32'(pixel_color), 32'd0);
        check("midrst_fdone", 32'(frame_done), 32'd0);
        mstep = 0;
        push_pass(0, 1);
        exp_frames++;
        @(posedge clk); #1 reset = 1'b0;
        wait_frame("t37_frame");

        @(posedge clk); #1 mode = 1'b1;
        for (int i = 0; i < 7; i++) begin
`ifdef MULTI_LINE_ANIMATOR_BOUNCE_EN
            do_update(bseq[i]);
`else
            do_update((mstep + 1) % ST);
`endif
        end

        repeat (50) @(posedge clk);
        check("final_drained", 32'(exp_q.size()), 32'd0);
        check("frame_count", 32'(fd_count), 32'(exp_frames));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
